// File: rtl/cps_gfxrom_pkg.sv
// Shared types and widths for the CPS-B graphics ROM fetch path.
package cps_gfxrom_pkg;

  localparam int unsigned ROMA_W  = 23;
  localparam int unsigned MEM_AW  = 24;
  localparam int unsigned MEM_DW  = 64;
  localparam int unsigned ROMD_W  = 32;
  localparam int unsigned LAYER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } gfx_state_e;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } half_sel_e;

  typedef struct packed {
    logic [ROMA_W-1:0] roma;
    half_sel_e         half;
  } gfx_req_t;

  // Word address in external memory; the sum wraps modulo 2^MEM_AW.
  function automatic logic [MEM_AW-1:0] rom_to_mem(input logic [MEM_AW-1:0] base,
                                                   input logic [ROMA_W-1:0] roma);
    return MEM_AW'(base + {1'b0, roma});
  endfunction

  function automatic logic [ROMD_W-1:0] pick_half(input logic [MEM_DW-1:0] word,
                                                  input half_sel_e     half);
    return (half == HALF_HI) ? word[MEM_DW-1:ROMD_W] : word[ROMD_W-1:0];
  endfunction

endpackage

// File: rtl/cps_b_gfxrom_if.sv
// External memory read bus between the tile fetcher and the memory controller.
interface cps_b_gfxrom_if;
  import cps_gfxrom_pkg::*;

  logic              req;
  logic [MEM_AW-1:0] addr;
  logic              ack;
  logic [MEM_DW-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/gfxrom_line_cache.sv
// One-entry cache of the last fetched tile word; only built with GFXROM_CACHE_EN.
`ifdef GFXROM_CACHE_EN
module gfxrom_line_cache
  import cps_gfxrom_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill_i,
  input  logic [ROMA_W-1:0] fill_roma_i,
  input  logic [MEM_DW-1:0] fill_data_i,
  input  logic [ROMA_W-1:0] look_roma_i,
  output logic              hit_c_o,
  output logic [MEM_DW-1:0] data_c_o
);

  logic              valid_q;
  logic [ROMA_W-1:0] tag_q;
  logic [MEM_DW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_roma_i;
      data_q  <= fill_data_i;
    end
  end

  assign hit_c_o  = valid_q && (tag_q == look_roma_i);
  assign data_c_o = data_q;

endmodule
`endif

// File: rtl/cps_b_gfxrom.sv
// CPS-B tile ROM fetcher: A-board requests -> 64-bit memory reads -> 32-bit pixel data.
// Optional one-entry line cache enabled by defining GFXROM_CACHE_EN.
module cps_b_gfxrom
  import cps_gfxrom_pkg::*;
#(
  parameter logic [MEM_AW-1:0] ROM_BASE = 24'h000000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ROMA_W-1:0]  ROMA,
  input  logic               ROMA_STB,
  input  logic               HALF_SEL,
  output logic [ROMD_W-1:0]  ROMD,
  output logic               ROMD_VLD,
  output logic [LAYER_W-1:0] ROMD_LAYER,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic               MEM_REQ,
  output logic [MEM_AW-1:0]  MEM_ADDR,
  input  logic               MEM_ACK,
  input  logic [MEM_DW-1:0]  MEM_DO
);

  gfx_state_e         state_q, state_d;
  gfx_req_t           cur_q, cur_d;
  gfx_req_t           pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [ROMD_W-1:0]  romd_q, romd_d;
  logic               romd_vld_q, romd_vld_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  gfx_req_t           stb_req_c;
  gfx_req_t           start_req_c;
  logic               start_c;
  logic               fill_c;
  logic               hit_c;
  logic [MEM_DW-1:0]  hit_data_c;

  cps_b_gfxrom_if mem_bus ();

  assign mem_bus.req   = mem_req_q;
  assign mem_bus.addr  = mem_addr_q;
  assign mem_bus.ack   = MEM_ACK;
  assign mem_bus.rdata = MEM_DO;
  assign MEM_REQ       = mem_bus.req;
  assign MEM_ADDR      = mem_bus.addr;

  assign ROMD       = romd_q;
  assign ROMD_VLD   = romd_vld_q;
  assign ROMD_LAYER = layer_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;

  // Acknowledges outside FETCH (including one for a fetch abandoned by reset) are dropped.
  assign fill_c = (state_q == ST_FETCH) && mem_bus.ack;

`ifdef GFXROM_CACHE_EN
  gfxrom_line_cache u_cache (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .fill_i      (fill_c),
    .fill_roma_i (cur_q.roma),
    .fill_data_i (mem_bus.rdata),
    .look_roma_i (start_req_c.roma),
    .hit_c_o     (hit_c),
    .data_c_o    (hit_data_c)
  );
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = '0;
`endif

  // Pick the request to launch this cycle: a waiting one always goes before a new strobe.
  always_comb begin
    stb_req_c.roma = ROMA;
    stb_req_c.half = half_sel_e'(HALF_SEL);
    start_c        = 1'b0;
    start_req_c    = pend_q;
    case (state_q)
      ST_IDLE: begin
        start_c = pend_vld_q | ROMA_STB;
        if (!pend_vld_q) start_req_c = stb_req_c;
      end
      ST_RESP: start_c = pend_vld_q;
      default: start_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    romd_d     = romd_q;
    romd_vld_d = 1'b0;
    layer_d    = layer_q;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          pend_vld_d = ROMA_STB;
          if (ROMA_STB) pend_d = stb_req_c;
        end
      end
      ST_FETCH: begin
        if (ROMA_STB) begin
          pend_d     = stb_req_c;
          pend_vld_d = 1'b1;
          overrun_d  = overrun_q | pend_vld_q;
        end
        if (mem_bus.ack) begin
          mem_req_d  = 1'b0;
          romd_d     = pick_half(mem_bus.rdata, cur_q.half);
          romd_vld_d = 1'b1;
          layer_d    = cur_q.roma[ROMA_W-1 -: LAYER_W];
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d    = ST_IDLE;
        pend_vld_d = ROMA_STB;
        if (ROMA_STB) pend_d = stb_req_c;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_c) begin
      cur_d = start_req_c;
      if (hit_c) begin
        state_d    = ST_RESP;
        romd_d     = pick_half(hit_data_c, start_req_c.half);
        romd_vld_d = 1'b1;
        layer_d    = start_req_c.roma[ROMA_W-1 -: LAYER_W];
      end else begin
        state_d    = ST_FETCH;
        mem_req_d  = 1'b1;
        mem_addr_d = rom_to_mem(ROM_BASE, start_req_c.roma);
      end
    end

    busy_d = (state_d != ST_IDLE) || pend_vld_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      romd_q     <= '0;
      romd_vld_q <= 1'b0;
      layer_q    <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      romd_q     <= romd_d;
      romd_vld_q <= romd_vld_d;
      layer_q    <= layer_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_cps_b_gfxrom.sv
// Self-checking bench for cps_b_gfxrom: directed cases plus random traffic against a request-order model.
module tb_cps_b_gfxrom;
  import cps_gfxrom_pkg::*;

  localparam logic [23:0] BASE0 = 24'h100000;
  localparam logic [23:0] BASE1 = 24'hFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, half;
  logic [22:0] roma;
  logic [31:0] romd0, romd1;
  logic        vld0, vld1, busy0, busy1, ovr0, ovr1, req1;
  logic [2:0]  lay0, lay1;
  logic [23:0] addr1;

  cps_b_gfxrom_if mif ();

  cps_b_gfxrom #(.ROM_BASE(BASE0)) dut0 (
    .CLK(clk), .RESET(rst), .ROMA(roma), .ROMA_STB(stb), .HALF_SEL(half),
    .ROMD(romd0), .ROMD_VLD(vld0), .ROMD_LAYER(lay0), .BUSY(busy0), .OVERRUN(ovr0),
    .MEM_REQ(mif.req), .MEM_ADDR(mif.addr), .MEM_ACK(mif.ack), .MEM_DO(mif.rdata)
  );

  cps_b_gfxrom #(.ROM_BASE(BASE1)) dut1 (
    .CLK(clk), .RESET(rst), .ROMA(roma), .ROMA_STB(stb), .HALF_SEL(half),
    .ROMD(romd1), .ROMD_VLD(vld1), .ROMD_LAYER(lay1), .BUSY(busy1), .OVERRUN(ovr1),
    .MEM_REQ(req1), .MEM_ADDR(addr1), .MEM_ACK(mif.ack), .MEM_DO(mif.rdata)
  );

  typedef struct packed {
    logic [22:0] roma;
    logic        half;
  } mreq_t;

  int    n_chk = 0, n_err = 0;
  int    n_ack, n_resp, wait_cnt;
  bit    model_en, mem_auto, ack_prev;
  bit    cur_v, pend_v, m_ovr;
  mreq_t cur, pend;
  logic [31:0] last_d;
  logic [2:0]  last_l;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [23:0] a);
    return {8'hC3, a ^ 24'h5A5A5A, 8'h96, a};
  endfunction

  function automatic logic [23:0] eaddr(input logic [23:0] base, input logic [22:0] r);
    logic [24:0] s;
    s = {1'b0, base} + {2'b00, r};
    return s[23:0];
  endfunction

  // One clock: sample at the falling edge, check against the model, then play the memory.
  task automatic cyc();
    logic [63:0] w;
    logic [31:0] e;
    @(negedge clk);
    if (model_en) begin
      chk("busy", busy0, cur_v);
      chk("overrun", ovr0, m_ovr);
      if (!cur_v) chk("req_idle", mif.req, 0);
      if (ack_prev) chk("ack_to_vld", vld0, 1);
`ifndef GFXROM_CACHE_EN
      if (vld0) chk("vld_no_ack", ack_prev, 1);
`endif
      chk("vld_pair", vld1, vld0);
      if (vld0) begin
        chk("vld_expected", cur_v, 1);
        w = mem_word(eaddr(BASE0, cur.roma));
        e = cur.half ? w[63:32] : w[31:0];
        chk("romd", romd0, e);
        chk("layer", lay0, cur.roma[22:20]);
        last_d = e;
        last_l = cur.roma[22:20];
        n_resp++;
        if (pend_v) begin
          cur    = pend;
          pend_v = 0;
        end else cur_v = 0;
      end else begin
        chk("romd_hold", romd0, last_d);
        chk("layer_hold", lay0, last_l);
      end
    end
    if (mem_auto) begin
      mif.ack  = 1'b0;
      ack_prev = 0;
      if (mif.req) begin
        if (wait_cnt == 0) begin
          if (model_en) begin
            chk("ack_cur", cur_v, 1);
            chk("addr0", mif.addr, eaddr(BASE0, cur.roma));
            chk("addr1", addr1, eaddr(BASE1, cur.roma));
          end
          mif.ack   = 1'b1;
          mif.rdata = mem_word(mif.addr);
          ack_prev  = 1;
          n_ack++;
          wait_cnt  = $urandom_range(0, 3);
        end else wait_cnt--;
      end
    end
  endtask

  task automatic drive_stb(input logic [22:0] r, input logic h);
    mreq_t q;
    q.roma = r;
    q.half = h;
    roma = r;
    half = h;
    stb  = 1'b1;
    if (model_en) begin
      if (!cur_v) begin
        cur   = q;
        cur_v = 1;
      end else if (pend_v) begin
        pend  = q;
        m_ovr = 1;
      end else begin
        pend   = q;
        pend_v = 1;
      end
    end
  endtask

  task automatic do_reset();
    model_en  = 0;
    mem_auto  = 0;
    rst       = 1'b1;
    stb       = 1'b0;
    mif.ack   = 1'b0;
    mif.rdata = '0;
    cyc();
    cyc();
    rst      = 1'b0;
    cur_v    = 0;
    pend_v   = 0;
    m_ovr    = 0;
    last_d   = '0;
    last_l   = '0;
    ack_prev = 0;
    wait_cnt = 0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_req"}, mif.req, 0);
    chk({p, "_addr"}, mif.addr, 0);
    chk({p, "_romd"}, romd0, 0);
    chk({p, "_vld"}, vld0, 0);
    chk({p, "_layer"}, lay0, 0);
    chk({p, "_busy"}, busy0, 0);
    chk({p, "_ovr"}, ovr0, 0);
    chk({p, "_req1"}, req1, 0);
    chk({p, "_addr1"}, addr1, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          a0, k, base_resp;
    logic [22:0] r, last_r;
    logic [63:0] w;

    rst = 1'b1; stb = 1'b0; roma = '0; half = 1'b0;
    mif.ack = 1'b0; mif.rdata = '0;
    n_ack = 0; n_resp = 0; last_r = '0;
    do_reset();
    chk_reset("por");

    // Single fetch with the upper half selected, acknowledged in the third request cycle.
    drive_stb(23'h012345, 1'b1);
    cyc();
    stb = 1'b0;
    chk("sf_req", mif.req, 1);
    chk("sf_addr", mif.addr, 24'h112345);
    chk("sf_addr_wrap1", addr1, 24'h012344);
    chk("sf_busy", busy0, 1);
    cyc();
    cyc();
    chk("sf_req_held", mif.req, 1);
    chk("sf_addr_held", mif.addr, 24'h112345);
    mif.ack = 1'b1;
    mif.rdata = 64'hDEADBEEF_01234567;
    cyc();
    mif.ack = 1'b0;
    chk("sf_vld", vld0, 1);
    chk("sf_romd", romd0, 32'hDEADBEEF);
    chk("sf_layer", lay0, 0);
    chk("sf_req_drop", mif.req, 0);
    cyc();
    chk("sf_vld_once", vld0, 0);
    chk("sf_romd_hold", romd0, 32'hDEADBEEF);
    chk("sf_idle", busy0, 0);

    // Address wrap on the instance with base 24'hFFFFFF.
    drive_stb(23'h000002, 1'b0);
    cyc();
    stb = 1'b0;
    chk("wrap_addr1", addr1, 24'h000001);
    chk("wrap_addr0", mif.addr, 24'h100002);
    mif.ack = 1'b1;
    mif.rdata = 64'h01234567_89ABCDEF;
    cyc();
    mif.ack = 1'b0;
    chk("wrap_romd0", romd0, 32'h89ABCDEF);
    chk("wrap_romd1", romd1, 32'h89ABCDEF);
    cyc();

    // Three back-to-back strobes: B is overwritten by C.
    do_reset();
    model_en = 1; mem_auto = 1; wait_cnt = 2;
    base_resp = n_resp;
    drive_stb(23'h100010, 1'b0); cyc();
    drive_stb(23'h200020, 1'b1); cyc();
    drive_stb(23'h300030, 1'b1); cyc();
    stb = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    chk("ovr_resp_count", n_resp - base_resp, 2);
    chk("ovr_sticky", ovr0, 1);
    do_reset();
    chk_reset("ovr_rst");

    // Reset while a fetch is outstanding; its late acknowledge must be ignored.
    drive_stb(23'h054321, 1'b1);
    cyc();
    stb = 1'b0;
    chk("rmf_req", mif.req, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rmf_req_clr", mif.req, 0);
    cyc();
    mif.ack = 1'b1;
    mif.rdata = 64'hFEEDFACE_CAFEF00D;
    cyc();
    mif.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rmf_no_vld", vld0, 0);
      cyc();
    end
    chk_reset("rmf");

    // Same address twice, low half then high half.
    do_reset();
    mem_auto = 1; wait_cnt = 1;
    a0 = n_ack;
    r = 23'h0ABCDE;
    w = mem_word(eaddr(BASE0, r));
    drive_stb(r, 1'b0);
    cyc();
    stb = 1'b0;
    for (k = 0; k < 10 && !vld0; k++) cyc();
    chk("c1_vld", vld0, 1);
    chk("c1_romd", romd0, w[31:0]);
    cyc();
    cyc();
    drive_stb(r, 1'b1);
    cyc();
    stb = 1'b0;
`ifdef GFXROM_CACHE_EN
    chk("c2_hit_latency", vld0, 1);
    chk("c2_no_req", mif.req, 0);
`endif
    for (k = 0; k < 10 && !vld0; k++) cyc();
    chk("c2_vld", vld0, 1);
    chk("c2_romd", romd0, w[63:32]);
    cyc();
`ifdef GFXROM_CACHE_EN
    chk("c_fetches", n_ack - a0, 1);
`else
    chk("c_fetches", n_ack - a0, 2);
`endif

    // Random traffic against the model.
    do_reset();
    model_en = 1; mem_auto = 1;
    n_ack = 0; n_resp = 0;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      stb  = 1'b0;
      roma = 23'($urandom);
      half = 1'($urandom);
      if ($urandom_range(0, 99) < 30) begin
        r = ($urandom_range(0, 3) == 0) ? last_r : 23'($urandom);
        drive_stb(r, 1'($urandom));
        last_r = r;
      end
    end
    cyc();
    stb = 1'b0;
    for (int i = 0; i < 100 && cur_v; i++) cyc();
    cyc();
    chk("drain", cur_v, 0);
    chk("rand_busy_end", busy0, 0);
`ifndef GFXROM_CACHE_EN
    chk("fetch_count", n_ack, n_resp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cps_b_gfxrom.md
CPS_B_GFXROM -- requirements
Module: cps_b_gfxrom

Interface
REQ-001 SHALL have parameter ROM_BASE, default 24'h000000: word offset of the tile ROM region within external memory.
REQ-002 SHALL have port CLK, input, 1: sole clock.
REQ-003 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port ROMA, input, 23: tile ROM address from the A-board; one 64-bit word per address.
REQ-005 SHALL have port ROMA_STB, input, 1: one-cycle pulse marking ROMA and HALF_SEL as valid.
REQ-006 SHALL have port HALF_SEL, input, 1: selects the returned half of the word (0 = [31:0], 1 = [63:32]).
REQ-007 SHALL have port ROMD, output, 32: pixel data returned to the A-board.
REQ-008 SHALL have port ROMD_VLD, output, 1: one-cycle pulse marking ROMD as valid.
REQ-009 SHALL have port ROMD_LAYER, output, 3: ROMA[22:20] of the request being answered.
REQ-010 SHALL have port BUSY, output, 1: high when the state is not IDLE or a request is pending.
REQ-011 SHALL have port OVERRUN, output, 1: sticky flag set when a pending request is overwritten.
REQ-012 SHALL have port MEM_REQ, output, 1: external memory read request, held high until acknowledged.
REQ-013 SHALL have port MEM_ADDR, output, 24: external memory 64-bit word address.
REQ-014 SHALL have port MEM_ACK, input, 1: one-cycle pulse; MEM_DO is valid in the same cycle.
REQ-015 SHALL have port MEM_DO, input, 64: external memory read data.

Function
REQ-016 SHALL implement a state machine with states IDLE, FETCH and RESP.
REQ-017 SHALL capture ROMA and HALF_SEL together on a ROMA_STB; HALF_SEL is not resampled later.
REQ-018 SHALL compute MEM_ADDR as ROM_BASE + {1'b0, ROMA}, truncated to 24 bits (wraps modulo 2^24).
REQ-019 SHALL, on ROMA_STB in IDLE at cycle N, enter FETCH and drive MEM_REQ=1 with a stable MEM_ADDR from cycle N+1.
REQ-020 SHALL, on MEM_ACK in FETCH at cycle M, drop MEM_REQ at M+1, register MEM_DO, and enter RESP.
REQ-021 SHALL, in RESP, pulse ROMD_VLD for exactly one cycle with the selected half on ROMD and ROMD_LAYER set.
REQ-022 SHALL hold ROMD and ROMD_LAYER at their last values while ROMD_VLD=0.
REQ-023 SHALL latch a ROMA_STB arriving in FETCH or RESP into a one-deep pending slot.
REQ-024 SHALL, on a ROMA_STB while the pending slot is full, overwrite the slot with the newest request and set OVERRUN.
REQ-025 SHALL leave RESP for FETCH (or the cache-hit path) when a request is pending, otherwise for IDLE; the pending slot empties on that transition.
REQ-026 SHALL place a pending request and a simultaneous new ROMA_STB in RESP as follows: the pending request is consumed and the new one takes the slot.
REQ-027 SHALL ignore MEM_ACK when the state is not FETCH.
REQ-028 SHALL, with no cache hit, answer with latency ROMD_VLD = MEM_ACK cycle + 1.

Reset
REQ-029 SHALL, with RESET high at a CLK edge, set state=IDLE, pending slot empty, MEM_REQ=0, MEM_ADDR=0, ROMD=0, ROMD_VLD=0, ROMD_LAYER=0, BUSY=0, OVERRUN=0 and cache valid=0.
REQ-030 SHALL abandon a fetch in progress on reset, and SHALL ignore any later MEM_ACK for that fetch.

Configuration
REQ-031 SHALL, when macro GFXROM_CACHE_EN is defined, hold a one-entry cache of the last fetched address and its 64-bit data with a valid flag.
REQ-032 SHALL, on a cache hit, skip MEM_REQ and go directly to RESP, giving ROMD_VLD one cycle after ROMA_STB (IDLE) or one cycle after leaving RESP (pending).
REQ-033 SHALL refill the cache on every MEM_ACK accepted in FETCH.
REQ-034 SHALL, when GFXROM_CACHE_EN is undefined, fetch every request from memory and contain no cache storage.

Structure
REQ-035 SHALL put the state enum, ROMA/MEM address widths and the HALF_SEL encoding in shared package cps_gfxrom_pkg.
REQ-036 SHALL implement the cache as sub-module gfxrom_line_cache, instantiated only under GFXROM_CACHE_EN.

Verification
REQ-037 SHALL test a single fetch: ROMA=23'h012345, HALF_SEL=1, ROM_BASE=24'h100000, ACK at 3 cycles with MEM_DO=64'hDEADBEEF_01234567. Required: MEM_ADDR=24'h112345, ROMD=32'hDEADBEEF, ROMD_LAYER=0, one ROMD_VLD pulse.
REQ-038 SHALL test address wrap: ROM_BASE=24'hFFFFFF with ROMA=23'h000002. Required: MEM_ADDR=24'h000001.
REQ-039 SHALL test overrun: three strobes A, B, C in consecutive cycles. Required: responses for A and C only, OVERRUN=1 and held until reset.
REQ-040 SHALL test reset mid-fetch: RESET in FETCH, then MEM_ACK two cycles later. Required: no ROMD_VLD, MEM_REQ=0, all outputs at reset values.
REQ-041 SHALL test the cache (GFXROM_CACHE_EN): the same ROMA twice, HALF_SEL 0 then 1. Required: one MEM_REQ, the second ROMD_VLD one cycle after its strobe, ROMD = the low then the high half.
REQ-042 SHALL test the no-cache build: the same stimulus as REQ-041. Required: two MEM_REQ fetches.
